// File: rtl/gf180mcu_bist_pkg.sv
// Shared types and constants for the gf180mcu logic-cell BIST controllers.
package gf180mcu_bist_pkg;

   localparam int unsigned VEC_W   = 3;
   localparam int unsigned ERR_W   = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ERR_SAT = 15;
   localparam int unsigned VEC_LAST = (1 << VEC_W) - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CHECK   = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   // Ideal NAND3 response for a {A3,A2,A1} vector.
   function automatic logic nand3_expect(input logic [VEC_W-1:0] vec);
      return ~(&vec);
   endfunction

endpackage

// File: rtl/gf180mcu_bist_settle_cnt.sv
// Down-counter with synchronous load; tc_c flags a count of zero.
module gf180mcu_bist_settle_cnt #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             count_en,
   output logic             tc_c
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count_en && count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign tc_c = (count == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_nand3.sv
// BIST controller for a NAND3 cell: sweeps all input vectors, counts ZN
// mismatches and reports the first failing vector.
module gf180mcu_fd_sc_mcu7t5v0__bist_nand3
   import gf180mcu_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned PASSES     = 1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   input  logic             ZN,
   output logic             A1,
   output logic             A2,
   output logic             A3,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [VEC_W-1:0] FAIL_VEC
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("SETTLE_CYC must be in 1..15");
   end
   if (PASSES < 1 || PASSES > 15) begin : g_bad_passes
      $error("PASSES must be in 1..15");
   end

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] PASS_LAST   = CNT_W'(PASSES - 1);

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic [CNT_W-1:0] pass_cnt;
   logic             settle_load_c;
   logic             settle_en_c;
   logic             settle_tc_c;
   logic             mismatch_c;
   logic             last_vec_c;

   assign {A3, A2, A1} = vec;

   // Four-state compare so an X or Z on ZN is a mismatch.
   assign mismatch_c    = (ZN !== nand3_expect(vec));
   assign last_vec_c    = (vec == VEC_W'(VEC_LAST)) && (pass_cnt == PASS_LAST);
   assign settle_load_c = ((state == IDLE) && START) || (state == CHECK);
   assign settle_en_c   = (state == SETTLE);

   gf180mcu_bist_settle_cnt #(
      .WIDTH(CNT_W)
   ) u_settle_cnt (
      .clk      (CLK),
      .rst_n    (RN),
      .load     (settle_load_c),
      .load_val (SETTLE_LOAD),
      .count_en (settle_en_c),
      .tc_c     (settle_tc_c)
   );

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= IDLE;
         vec      <= '0;
         pass_cnt <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         PASS     <= 1'b0;
         ERR_CNT  <= '0;
         FAIL_VEC <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  ERR_CNT  <= '0;
                  FAIL_VEC <= '0;
                  PASS     <= 1'b0;
                  vec      <= '0;
                  pass_cnt <= '0;
                  BUSY     <= 1'b1;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_tc_c) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               // ERR_CNT never wraps, so zero means no earlier mismatch this run.
               if (mismatch_c) begin
                  if (ERR_CNT != ERR_W'(ERR_SAT)) begin
                     ERR_CNT <= ERR_CNT + ERR_W'(1);
                  end
                  if (ERR_CNT == '0) begin
                     FAIL_VEC <= vec;
                  end
               end
               if (last_vec_c) begin
                  state <= DONE_ST;
               end else begin
                  vec <= vec + VEC_W'(1);
                  if (vec == VEC_W'(VEC_LAST)) begin
                     pass_cnt <= pass_cnt + CNT_W'(1);
                  end
                  state <= SETTLE;
               end
            end
            DONE_ST: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               PASS  <= (ERR_CNT == '0);
               vec   <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__bist_nand3.md
GF180MCU_FD_SC_MCU7T5V0__BIST_NAND3 -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__bist_nand3

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be CLK and the reset port SHALL be RN.
REQ-002 Parameter SETTLE_CYC, default 2, meaning cycles between driving a vector and sampling ZN; legal range 1..15.
REQ-003 Parameter PASSES, default 1, meaning number of full 8-vector sweeps per run; legal range 1..15.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RN  input  1  asynchronous active-low reset.
REQ-006 START  input  1  run request, sampled only in IDLE.
REQ-007 ZN  input  1  output of the NAND3 cell under test.
REQ-008 A1, A2, A3  output  1 each  drive the NAND3 cell inputs; the current vector is {A3,A2,A1}.
REQ-009 BUSY  output  1  high from the cycle after START is accepted until DONE is asserted.
REQ-010 DONE  output  1  one-cycle pulse at end of run.
REQ-011 PASS  output  1  high when the last completed run had ERR_CNT==0.
REQ-012 ERR_CNT  output  4  mismatch count for the last run, saturating.
REQ-013 FAIL_VEC  output  3  first failing {A3,A2,A1} vector of the last run.

Function
REQ-014 States SHALL be IDLE, SETTLE, CHECK, DONE_ST.
REQ-015 IDLE: on START=1, SHALL clear ERR_CNT, FAIL_VEC, PASS, vector, pass count and settle count, then go to SETTLE; A outputs SHALL show vector 0 from the next cycle.
REQ-016 SETTLE: SHALL hold the vector for exactly SETTLE_CYC cycles, then go to CHECK.
REQ-017 CHECK (1 cycle): expected = ~(A1&A2&A3); a mismatch SHALL occur when ZN !== expected, so X or Z on ZN counts as a mismatch.
REQ-018 On mismatch, ERR_CNT SHALL increment and saturate at 15; FAIL_VEC SHALL load the vector only on the first mismatch of the run.
REQ-019 After CHECK, the vector SHALL increment modulo 8; on wrap from 7 to 0 the pass count SHALL increment; if the last vector of pass PASSES-1 was checked, the next state SHALL be DONE_ST, else SETTLE.
REQ-020 DONE_ST (1 cycle): DONE=1, BUSY=0, PASS=(ERR_CNT==0) including the mismatch from the final CHECK; the next state SHALL be IDLE.
REQ-021 Latency: DONE SHALL assert exactly 8*PASSES*(SETTLE_CYC+1)+1 cycles after the edge that accepted START.
REQ-022 START asserted outside IDLE SHALL be ignored; a START held high SHALL be accepted again only once the block is back in IDLE.
REQ-023 PASS, ERR_CNT and FAIL_VEC SHALL hold their values from DONE_ST until the next accepted START.
REQ-024 A1..A3 SHALL hold their last vector while in DONE_ST, and SHALL be driven to 0 in IDLE.

Reset
REQ-025 RN low SHALL asynchronously force IDLE, A1=A2=A3=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0 and all counters to 0.
REQ-026 Reset mid-run SHALL abort the run with no DONE pulse; the first START after RN rises SHALL run a complete fresh sweep.

Structure
REQ-027 The state enum, vector width (3), ERR_CNT width (4) and saturation value (15) SHALL live in the shared package gf180mcu_bist_pkg.
REQ-028 The settle counter SHALL be one sub-module, gf180mcu_bist_settle_cnt (load/count/terminal-count), reusable by later bist_nand2/nand4 blocks.
REQ-029 Parameter values outside their legal range SHALL be rejected at elaboration.

Verification
REQ-030 Ideal NAND3 model on A/ZN, SETTLE_CYC=2, PASSES=1, START pulse -> DONE 25 cycles later, PASS=1, ERR_CNT=0, FAIL_VEC=0.
REQ-031 ZN stuck at 1 -> ERR_CNT=1, FAIL_VEC=3'b111, PASS=0.
REQ-032 ZN stuck at 0, PASSES=1 -> ERR_CNT=7, FAIL_VEC=3'b000; same fault with PASSES=3 -> ERR_CNT=15 (saturated, 21 raw mismatches).
REQ-033 ZN driven X for vector 5 only, with an ideal model otherwise -> ERR_CNT=1, FAIL_VEC=3'b101.
REQ-034 RN pulsed low at cycle 10 of a run -> all outputs at reset values immediately, no DONE pulse; next START -> full 25-cycle run with PASS=1.
REQ-035 START held high continuously -> back-to-back runs with DONE pulses exactly 26 cycles apart; extra START pulses during BUSY -> no effect.
